vram_arbiter: RTL and testbench
===============================

Name: vram_arbiter

Overview:
- Shares one single-port video RAM (tile/palette store, 1-cycle synchronous read) between two requesters:
  - the video fetch path (tile_block reads, tile_RAM_addr / palette_RAM_addr side);
  - a CPU-side read/write port.
- Video has priority while the beam is inside the visible frame window.
- The CPU has priority during blanking and out-of-frame time.
- A starvation guard bounds CPU wait time.
- Sits between video_top's fetch logic and the RAM macro.

Parameters:
- ADDR_W, 16, RAM address width (matches tile_RAM_addr/palette_RAM_addr).
- DATA_W, 8, RAM data width.
- STARVE_MAX, 4, consecutive lost arbitration cycles before a pending CPU request is forced through (range 1..15).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-low
- active  in  1  1 = beam inside frame window (row_ok & col_ok)
- vid_req  in  1  video read request, one per cycle, no backpressure
- vid_addr  in  ADDR_W  video read address
- vid_valid  out  1  video read data valid
- vid_rdata  out  DATA_W  video read data
- vid_miss  out  1  1-cycle pulse: video request of 2 cycles earlier was dropped
- cpu_req  in  1  CPU request, held until cpu_ack
- cpu_we  in  1  1 = write, 0 = read
- cpu_addr  in  ADDR_W  CPU address
- cpu_wdata  in  DATA_W  CPU write data
- cpu_ack  out  1  1-cycle completion pulse (reads and writes)
- cpu_rdata  out  DATA_W  CPU read data, valid with cpu_ack
- mem_en  out  1  RAM enable
- mem_we  out  1  RAM write enable
- mem_addr  out  ADDR_W  RAM address
- mem_wdata  out  DATA_W  RAM write data
- mem_rdata  in  DATA_W  RAM read data, 1 cycle after mem_en

Behaviour:
- Reset (rst==0 at a clk edge):
  - all outputs 0; CPU FSM to IDLE; starve_cnt to 0; both in-flight owner tags cleared.
  - Data returning from a pre-reset access raises no valid or ack.
  - A CPU transaction in progress is aborted without cpu_ack; the CPU must re-issue.
- Pipeline, arbitration decision in cycle N:
  - N+1: mem_* registered outputs driven.
  - N+2: mem_rdata arrives, routed by the registered owner tag.
  - Video latency is exactly 2 cycles, fully pipelined (one result per cycle).
  - No grant in a cycle: mem_en=0, mem_we=0, mem_addr/mem_wdata hold.
- CPU FSM:
  - IDLE: cpu_req sampled; if granted -> ISSUED.
  - ISSUED (mem access driven) -> WAIT.
  - WAIT: cpu_ack=1, cpu_rdata=mem_rdata (reads; unchanged for writes) -> IDLE.
  - cpu_req is ignored in ISSUED and in WAIT. It is re-sampled from the cycle after cpu_ack.
  - cpu_pending = cpu_req && state==IDLE.
- Arbitration:
  - active=1: video wins, unless cpu_pending && starve_cnt==STARVE_MAX. In that case the CPU wins and a simultaneous vid_req is dropped (vid_miss=1 at N+2, vid_valid=0).
  - active=0: CPU wins. A simultaneous vid_req is dropped and flagged the same way.
  - Only one requester: it is granted.
- starve_cnt:
  - +1 each cycle cpu_pending loses; saturates at STARVE_MAX.
  - Cleared to 0 on CPU grant, or in any cycle with cpu_pending=0.
  - Guarantees CPU grant within STARVE_MAX+1 cycles of assertion.
- Writes:
  - mem_we=1 only for a CPU write grant.
  - The video path never writes.
  - Read-during-write returns RAM macro behaviour; no bypass.
- Hold behaviour:
  - vid_rdata holds its last value when vid_valid=0.
  - cpu_rdata holds until the next CPU read ack.

Test Plan:
- Reset: rst=0 for 2 cycles with vid_req=1, cpu_req=1 -> all outputs 0. After release with active=1, first vid_valid 2 cycles after first sampled vid_req; no stale ack.
- Video streaming: active=1, vid_req=1 for 8 cycles, addresses 0x0100..0x0107, RAM preloaded data=addr[7:0] -> vid_valid high 8 consecutive cycles, vid_rdata 0x00..0x07 in order, starting 2 cycles after first request.
- CPU during blanking: active=0, write 0xA5 to 0x1234, then read 0x1234 -> each cpu_ack 2 cycles after grant, read cpu_rdata=0xA5, mem_we high exactly one cycle.
- Starvation guard: active=1, vid_req=1 continuously, cpu_req read of 0x0010 with STARVE_MAX=4 -> CPU granted on 5th cycle of pending; that cycle's video request dropped, vid_miss pulse 2 cycles later; cpu_ack 2 cycles after grant.
- Collision at active edge: active falls 1->0 while vid_req=1 and cpu_req=1 -> CPU granted that cycle, vid_miss=1 two cycles later. No double mem_en owner; mem_we matches cpu_we.
- Reset mid-operation: rst=0 in the cycle a CPU read is ISSUED -> no cpu_ack ever for it. Post-reset re-request completes normally with correct data.

Source files
------------

// File: rtl/vram_arbiter.sv
// Arbiter that shares one single-port video RAM between the video fetch path and a CPU port.
// Video owns the RAM inside the visible window; the CPU owns it during blanking, with a starvation guard.
module vram_arbiter #(
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 8,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              active,
    input  logic              vid_req,
    input  logic [ADDR_W-1:0] vid_addr,
    output logic              vid_valid,
    output logic [DATA_W-1:0] vid_rdata,
    output logic              vid_miss,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        CPU_IDLE   = 2'd0,
        CPU_ISSUED = 2'd1,
        CPU_WAIT   = 2'd2
    } cpu_state_e;

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    cpu_state_e        state_q, state_d;
    logic [3:0]        starve_q, starve_d;
    logic              mem_en_q, mem_en_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              vid_tag1_q, vid_tag1_d;
    logic              vid_valid_q, vid_valid_d;
    logic              vid_miss1_q, vid_miss1_d;
    logic              vid_miss_q, vid_miss_d;
    logic              cpu_rd_q, cpu_rd_d;
    logic [DATA_W-1:0] vid_hold_q, vid_hold_d;
    logic [DATA_W-1:0] cpu_hold_q, cpu_hold_d;

    logic cpu_pending_s;
    logic cpu_grant_s;
    logic vid_grant_s;

    // Arbitration, CPU FSM, starvation counter and next-state of the RAM pipeline
    always_comb begin
        state_d     = state_q;
        starve_d    = starve_q;
        mem_en_d    = 1'b0;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        cpu_rd_d    = cpu_rd_q;

        cpu_pending_s = cpu_req && (state_q == CPU_IDLE);
        if (active) begin
            cpu_grant_s = cpu_pending_s && ((starve_q == STARVE_LIM) || !vid_req);
        end else begin
            cpu_grant_s = cpu_pending_s;
        end
        vid_grant_s = vid_req && !cpu_grant_s;

        if (!cpu_pending_s || cpu_grant_s) begin
            starve_d = 4'd0;
        end else if (starve_q != STARVE_LIM) begin
            starve_d = starve_q + 4'd1;
        end else begin
            starve_d = starve_q;
        end

        case (state_q)
            CPU_IDLE: begin
                if (cpu_grant_s) begin
                    state_d = CPU_ISSUED;
                end else begin
                    state_d = CPU_IDLE;
                end
            end
            CPU_ISSUED: state_d = CPU_WAIT;
            CPU_WAIT:   state_d = CPU_IDLE;
            default:    state_d = CPU_IDLE;
        endcase

        if (cpu_grant_s) begin
            mem_en_d    = 1'b1;
            mem_we_d    = cpu_we;
            mem_addr_d  = cpu_addr;
            mem_wdata_d = cpu_wdata;
            cpu_rd_d    = !cpu_we;
        end else if (vid_grant_s) begin
            mem_en_d   = 1'b1;
            mem_addr_d = vid_addr;
        end else begin
            mem_en_d = 1'b0;
        end

        // Owner tags travel alongside the access so returning data is routed without re-arbitrating
        vid_tag1_d  = vid_grant_s;
        vid_valid_d = vid_tag1_q;
        vid_miss1_d = vid_req && !vid_grant_s;
        vid_miss_d  = vid_miss1_q;

        vid_hold_d = vid_valid_q ? mem_rdata : vid_hold_q;
        if ((state_q == CPU_WAIT) && cpu_rd_q) begin
            cpu_hold_d = mem_rdata;
        end else begin
            cpu_hold_d = cpu_hold_q;
        end
    end

    // State and pipeline registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= CPU_IDLE;
            starve_q    <= 4'd0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            vid_tag1_q  <= 1'b0;
            vid_valid_q <= 1'b0;
            vid_miss1_q <= 1'b0;
            vid_miss_q  <= 1'b0;
            cpu_rd_q    <= 1'b0;
            vid_hold_q  <= '0;
            cpu_hold_q  <= '0;
        end else begin
            state_q     <= state_d;
            starve_q    <= starve_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            vid_tag1_q  <= vid_tag1_d;
            vid_valid_q <= vid_valid_d;
            vid_miss1_q <= vid_miss1_d;
            vid_miss_q  <= vid_miss_d;
            cpu_rd_q    <= cpu_rd_d;
            vid_hold_q  <= vid_hold_d;
            cpu_hold_q  <= cpu_hold_d;
        end
    end

    // Read data passes straight through in its return cycle and holds afterwards
    assign vid_rdata = vid_valid_q ? mem_rdata : vid_hold_q;
    assign cpu_rdata = ((state_q == CPU_WAIT) && cpu_rd_q) ? mem_rdata : cpu_hold_q;
    assign vid_valid = vid_valid_q;
    assign vid_miss  = vid_miss_q;
    assign cpu_ack   = (state_q == CPU_WAIT);
    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_vram_arbiter.sv
// Scoreboard testbench for vram_arbiter: a RAM model preloaded with data = addr[7:0],
// expected video/CPU results and miss pulses queued with the cycle they must appear in.
module tb_vram_arbiter;

    logic        clk = 1'b0;
    logic        rst, active, vid_req, cpu_req, cpu_we;
    logic [15:0] vid_addr, cpu_addr, mem_addr;
    logic [7:0]  cpu_wdata, vid_rdata, cpu_rdata, mem_wdata;
    logic [7:0]  mem_rdata = 8'h00;
    logic        vid_valid, vid_miss, cpu_ack, mem_en, mem_we;

    typedef struct {
        int         cyc;
        logic [7:0] data;
        bit         rd;
    } exp_t;

    exp_t       vid_q[$];
    exp_t       cpu_q[$];
    int         miss_q[$];
    exp_t       e;
    int         cyc    = 0;
    int         n_chk  = 0;
    int         n_fail = 0;
    logic [7:0] ram [0:65535];

    vram_arbiter #(.ADDR_W(16), .DATA_W(8), .STARVE_MAX(4)) dut (
        .clk(clk), .rst(rst), .active(active),
        .vid_req(vid_req), .vid_addr(vid_addr), .vid_valid(vid_valid),
        .vid_rdata(vid_rdata), .vid_miss(vid_miss),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Single-port RAM, read-first, 1-cycle synchronous read
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            mem_rdata <= ram[mem_addr];
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic test_reset();
        rst = 1'b0; active = 1'b1; vid_req = 1'b1; cpu_req = 1'b1; cpu_we = 1'b0;
        vid_addr = 16'h0042; cpu_addr = 16'h0033; cpu_wdata = 8'h00;
        for (int j = 0; j < 2; j++) begin
            tick();
            n_chk++;
            if ({vid_valid, vid_miss, cpu_ack, mem_en, mem_we} !== 5'b0 || mem_addr !== 16'h0 ||
                mem_wdata !== 8'h0 || vid_rdata !== 8'h0 || cpu_rdata !== 8'h0) begin
                n_fail++;
                $display("FAIL reset_outputs cyc=%0d got vv=%b vm=%b ack=%b en=%b we=%b addr=%h wd=%h vrd=%h crd=%h expected all zero",
                         cyc, vid_valid, vid_miss, cpu_ack, mem_en, mem_we, mem_addr, mem_wdata, vid_rdata, cpu_rdata);
            end
        end
        rst = 1'b1; cpu_req = 1'b0;
        vid_q.push_back('{cyc + 2, 8'h42, 1'b1});
        for (int j = 0; j < 4; j++) begin
            tick();
            vid_req = 1'b0;
            n_chk++;
            if (vid_q.size() > 0 && vid_q[0].cyc == cyc) begin
                e = vid_q.pop_front();
                if (vid_valid !== 1'b1 || vid_rdata !== e.data) begin
                    n_fail++;
                    $display("FAIL reset_first_vid cyc=%0d got valid=%b data=%h expected valid=1 data=%h", cyc, vid_valid, vid_rdata, e.data);
                end
            end else if (vid_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_vid_idle cyc=%0d got valid=%b expected 0", cyc, vid_valid);
            end
            n_chk++;
            if (cpu_ack !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_stale_ack cyc=%0d got ack=%b expected 0", cyc, cpu_ack);
            end
        end
    endtask

    task automatic test_video_stream();
        active = 1'b1; cpu_req = 1'b0;
        for (int i = 0; i < 11; i++) begin
            if (i < 8) begin
                vid_req  = 1'b1;
                vid_addr = 16'h0100 + 16'(i);
                vid_q.push_back('{cyc + 2, 8'(i), 1'b1});
            end else begin
                vid_req = 1'b0;
            end
            tick();
            n_chk++;
            if (vid_q.size() > 0 && vid_q[0].cyc == cyc) begin
                e = vid_q.pop_front();
                if (vid_valid !== 1'b1 || vid_rdata !== e.data) begin
                    n_fail++;
                    $display("FAIL stream_data cyc=%0d got valid=%b data=%h expected valid=1 data=%h", cyc, vid_valid, vid_rdata, e.data);
                end
            end else if (vid_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL stream_idle cyc=%0d got valid=%b expected 0", cyc, vid_valid);
            end
            n_chk++;
            if (mem_we !== 1'b0 || vid_miss !== 1'b0) begin
                n_fail++;
                $display("FAIL stream_no_write cyc=%0d got we=%b miss=%b expected 0 0", cyc, mem_we, vid_miss);
            end
        end
        n_chk++;
        if (vid_rdata !== 8'h07) begin
            n_fail++;
            $display("FAIL stream_hold got %h expected 07", vid_rdata);
        end
    endtask

    task automatic test_cpu_blanking();
        int we_cnt = 0;
        active = 1'b0; vid_req = 1'b0;
        for (int k = 0; k < 2; k++) begin
            cpu_req = 1'b1; cpu_we = (k == 0); cpu_addr = 16'h1234; cpu_wdata = 8'hA5;
            cpu_q.push_back('{cyc + 2, 8'hA5, k == 1});
            for (int j = 0; j < 4; j++) begin
                tick();
                if (mem_we === 1'b1) begin
                    we_cnt++;
                    n_chk++;
                    if (mem_addr !== 16'h1234 || mem_wdata !== 8'hA5) begin
                        n_fail++;
                        $display("FAIL blank_write_bus got addr=%h data=%h expected 1234 a5", mem_addr, mem_wdata);
                    end
                end
                n_chk++;
                if (cpu_q.size() > 0 && cpu_q[0].cyc == cyc) begin
                    e = cpu_q.pop_front();
                    if (cpu_ack !== 1'b1 || (e.rd && cpu_rdata !== e.data)) begin
                        n_fail++;
                        $display("FAIL blank_ack cyc=%0d got ack=%b rdata=%h expected ack=1 rdata=%h", cyc, cpu_ack, cpu_rdata, e.data);
                    end
                end else if (cpu_ack !== 1'b0) begin
                    n_fail++;
                    $display("FAIL blank_no_ack cyc=%0d got ack=%b expected 0", cyc, cpu_ack);
                end
                if (cpu_ack === 1'b1) cpu_req = 1'b0;
            end
        end
        n_chk++;
        if (we_cnt != 1 || cpu_rdata !== 8'hA5) begin
            n_fail++;
            $display("FAIL blank_summary got we_cycles=%0d rdata=%h expected 1 a5", we_cnt, cpu_rdata);
        end
    endtask

    task automatic test_starvation();
        active = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0010;
        for (int i = 0; i < 13; i++) begin
            if (i < 10) begin
                vid_req  = 1'b1;
                vid_addr = 16'h0200 + 16'(i);
                if (i == 0) cpu_req = 1'b1;
                if (i == 4) begin
                    miss_q.push_back(cyc + 2);
                    cpu_q.push_back('{cyc + 2, 8'h10, 1'b1});
                end else begin
                    vid_q.push_back('{cyc + 2, 8'(i), 1'b1});
                end
            end else begin
                vid_req = 1'b0;
            end
            tick();
            n_chk++;
            if (vid_q.size() > 0 && vid_q[0].cyc == cyc) begin
                e = vid_q.pop_front();
                if (vid_valid !== 1'b1 || vid_rdata !== e.data) begin
                    n_fail++;
                    $display("FAIL starve_vid cyc=%0d got valid=%b data=%h expected valid=1 data=%h", cyc, vid_valid, vid_rdata, e.data);
                end
            end else if (vid_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL starve_vid_idle cyc=%0d got valid=%b expected 0", cyc, vid_valid);
            end
            n_chk++;
            if (miss_q.size() > 0 && miss_q[0] == cyc) begin
                void'(miss_q.pop_front());
                if (vid_miss !== 1'b1) begin
                    n_fail++;
                    $display("FAIL starve_miss cyc=%0d got %b expected 1", cyc, vid_miss);
                end
            end else if (vid_miss !== 1'b0) begin
                n_fail++;
                $display("FAIL starve_no_miss cyc=%0d got %b expected 0", cyc, vid_miss);
            end
            n_chk++;
            if (cpu_q.size() > 0 && cpu_q[0].cyc == cyc) begin
                e = cpu_q.pop_front();
                if (cpu_ack !== 1'b1 || cpu_rdata !== e.data) begin
                    n_fail++;
                    $display("FAIL starve_ack cyc=%0d got ack=%b rdata=%h expected ack=1 rdata=%h", cyc, cpu_ack, cpu_rdata, e.data);
                end
            end else if (cpu_ack !== 1'b0) begin
                n_fail++;
                $display("FAIL starve_no_ack cyc=%0d got ack=%b expected 0", cyc, cpu_ack);
            end
            if (cpu_ack === 1'b1) cpu_req = 1'b0;
        end
    endtask

    task automatic test_active_edge();
        int cb = 0;
        active = 1'b1; vid_req = 1'b1; vid_addr = 16'h0150;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h0300; cpu_wdata = 8'h5A;
        vid_q.push_back('{cyc + 2, 8'h50, 1'b1});
        for (int j = 0; j < 5; j++) begin
            tick();
            if (j == 0) begin
                active = 1'b0; vid_addr = 16'h0151; cb = cyc;
                miss_q.push_back(cyc + 2);
                cpu_q.push_back('{cyc + 2, 8'h00, 1'b0});
                n_chk++;
                if (mem_en !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 16'h0150) begin
                    n_fail++;
                    $display("FAIL edge_vid_bus got en=%b we=%b addr=%h expected 1 0 0150", mem_en, mem_we, mem_addr);
                end
            end else begin
                vid_req = 1'b0;
            end
            if (cyc == cb + 1) begin
                n_chk++;
                if (mem_en !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 16'h0300 || mem_wdata !== 8'h5A) begin
                    n_fail++;
                    $display("FAIL edge_cpu_bus got en=%b we=%b addr=%h wd=%h expected 1 1 0300 5a", mem_en, mem_we, mem_addr, mem_wdata);
                end
            end
            n_chk++;
            if (vid_q.size() > 0 && vid_q[0].cyc == cyc) begin
                e = vid_q.pop_front();
                if (vid_valid !== 1'b1 || vid_rdata !== e.data) begin
                    n_fail++;
                    $display("FAIL edge_vid cyc=%0d got valid=%b data=%h expected valid=1 data=%h", cyc, vid_valid, vid_rdata, e.data);
                end
            end else if (vid_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL edge_vid_idle cyc=%0d got valid=%b expected 0", cyc, vid_valid);
            end
            n_chk++;
            if (miss_q.size() > 0 && miss_q[0] == cyc) begin
                void'(miss_q.pop_front());
                if (vid_miss !== 1'b1) begin
                    n_fail++;
                    $display("FAIL edge_miss cyc=%0d got %b expected 1", cyc, vid_miss);
                end
            end else if (vid_miss !== 1'b0) begin
                n_fail++;
                $display("FAIL edge_no_miss cyc=%0d got %b expected 0", cyc, vid_miss);
            end
            n_chk++;
            if (cpu_q.size() > 0 && cpu_q[0].cyc == cyc) begin
                void'(cpu_q.pop_front());
                if (cpu_ack !== 1'b1) begin
                    n_fail++;
                    $display("FAIL edge_ack cyc=%0d got %b expected 1", cyc, cpu_ack);
                end
            end else if (cpu_ack !== 1'b0) begin
                n_fail++;
                $display("FAIL edge_no_ack cyc=%0d got %b expected 0", cyc, cpu_ack);
            end
            if (cpu_ack === 1'b1) cpu_req = 1'b0;
        end
    endtask

    task automatic test_reset_mid_op();
        active = 1'b0; vid_req = 1'b0;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0020;
        for (int j = 0; j < 6; j++) begin
            tick();
            if (j == 0) rst = 1'b0;
            if (j == 1) begin
                rst = 1'b1;
                cpu_q.push_back('{cyc + 2, 8'h20, 1'b1});
            end
            n_chk++;
            if (cpu_q.size() > 0 && cpu_q[0].cyc == cyc) begin
                e = cpu_q.pop_front();
                if (cpu_ack !== 1'b1 || cpu_rdata !== e.data) begin
                    n_fail++;
                    $display("FAIL midrst_reissue cyc=%0d got ack=%b rdata=%h expected ack=1 rdata=%h", cyc, cpu_ack, cpu_rdata, e.data);
                end
            end else if (cpu_ack !== 1'b0) begin
                n_fail++;
                $display("FAIL midrst_no_ack cyc=%0d got ack=%b expected 0", cyc, cpu_ack);
            end
            if (cpu_ack === 1'b1) cpu_req = 1'b0;
        end
    endtask

    initial begin
        for (int a = 0; a < 65536; a++) ram[a] = 8'(a);
        test_reset();
        test_video_stream();
        test_cpu_blanking();
        test_starvation();
        test_active_edge();
        test_reset_mid_op();
        n_chk++;
        if (vid_q.size() != 0 || cpu_q.size() != 0 || miss_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain got vid=%0d cpu=%0d miss=%0d pending expected 0 0 0",
                     vid_q.size(), cpu_q.size(), miss_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
